// File: rtl/ps2_pkg.sv
// Shared constants, parser state type and event-word layout for the PS/2
// set-2 event decoder.
package ps2_pkg;

  // Set-2 scan-code bytes with special meaning to the decoder
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  // Prefix parser states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  // Event word layout: {ctrl, shift, brk, ext, code}
  localparam int EV_W         = 12;
  localparam int EV_CODE_LSB  = 0;
  localparam int EV_CODE_W    = 8;
  localparam int EV_EXT_BIT   = 8;
  localparam int EV_BRK_BIT   = 9;
  localparam int EV_SHIFT_BIT = 10;
  localparam int EV_CTRL_BIT  = 11;

  function automatic logic [EV_W-1:0] pack_event(
    input logic       ctrl,
    input logic       shift,
    input logic       brk,
    input logic       ext,
    input logic [7:0] code
  );
    return {ctrl, shift, brk, ext, code};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO with register storage.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is ignored and the caller decides what that means.
module ps2_event_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr_reg];
  assign level    = level_reg;

  // Storage write; contents need no reset since reads are gated by level
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_event_decoder.sv
// Turns validated set-2 scan-code bytes into key events: strips E0/F0
// prefixes, tracks Shift/Ctrl, counts accepted make events and queues the
// events for a valid/ready consumer.
import ps2_pkg::*;

module ps2_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_break,
  output logic                        ev_shift,
  output logic                        ev_ctrl,
  output logic [CNT_W-1:0]            press_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  parse_state_t     state_reg, state_next;
  logic             emit, emit_ext, emit_brk;
  logic             shift_l_reg, shift_r_reg, ctrl_l_reg, ctrl_r_reg;
  logic             shift_l_next, shift_r_next, ctrl_l_next, ctrl_r_next;
  logic [CNT_W-1:0] press_cnt_reg;
  logic             overflow_reg;
  logic [EV_W-1:0]  ev_word;
  logic [EV_W-1:0]  head_word;
  logic             fifo_full, fifo_empty, pop, accept;

  // Prefix parser: E0 always restarts as extended (dropping a pending break),
  // F0 adds break while keeping any extended prefix, anything else completes
  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    if (byte_valid) begin
      if (byte_data == SC_EXT) begin
        state_next = ST_EXT;
      end else if (byte_data == SC_BRK) begin
        state_next = (state_reg == ST_EXT || state_reg == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else begin
        emit       = 1'b1;
        emit_ext   = (state_reg == ST_EXT || state_reg == ST_EXT_BRK);
        emit_brk   = (state_reg == ST_BRK || state_reg == ST_EXT_BRK);
        state_next = ST_IDLE;
      end
    end
  end

  // Modifier state as it will be after the emitted event (make sets, break clears)
  always_comb begin
    shift_l_next = shift_l_reg;
    shift_r_next = shift_r_reg;
    ctrl_l_next  = ctrl_l_reg;
    ctrl_r_next  = ctrl_r_reg;
    if (emit) begin
      if (!emit_ext && byte_data == SC_LSHIFT) shift_l_next = !emit_brk;
      if (!emit_ext && byte_data == SC_RSHIFT) shift_r_next = !emit_brk;
      if (!emit_ext && byte_data == SC_CTRL)   ctrl_l_next  = !emit_brk;
      if ( emit_ext && byte_data == SC_CTRL)   ctrl_r_next  = !emit_brk;
    end
  end

  assign ev_word = pack_event(ctrl_l_next | ctrl_r_next, shift_l_next | shift_r_next,
                              emit_brk, emit_ext, byte_data);

  assign pop    = ev_valid && ev_ready;
  assign accept = emit && (!fifo_full || pop);

  // Parser state, modifiers (updated even when the event is dropped),
  // press counter (accepted makes only) and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      shift_l_reg   <= 1'b0;
      shift_r_reg   <= 1'b0;
      ctrl_l_reg    <= 1'b0;
      ctrl_r_reg    <= 1'b0;
      press_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_l_reg <= shift_l_next;
      shift_r_reg <= shift_r_next;
      ctrl_l_reg  <= ctrl_l_next;
      ctrl_r_reg  <= ctrl_r_next;
      if (accept && !emit_brk) press_cnt_reg <= press_cnt_reg + CNT_W'(1);
      if (emit && !accept)     overflow_reg  <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (emit),
    .push_data (ev_word),
    .pop       (pop),
    .pop_data  (head_word),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields read as zero whenever nothing is queued
  assign ev_valid  = !fifo_empty;
  assign ev_code   = ev_valid ? head_word[EV_CODE_LSB +: EV_CODE_W] : 8'h00;
  assign ev_ext    = ev_valid && head_word[EV_EXT_BIT];
  assign ev_break  = ev_valid && head_word[EV_BRK_BIT];
  assign ev_shift  = ev_valid && head_word[EV_SHIFT_BIT];
  assign ev_ctrl   = ev_valid && head_word[EV_CTRL_BIT];
  assign press_cnt = press_cnt_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_event_decoder.sv
// Bench for ps2_event_decoder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_ps2_event_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_shift, ev_ctrl;
  logic [CW-1:0] press_cnt;
  logic [3:0] fifo_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model: pending prefix flags, key-held flags, event queue
  bit          m_pe = 0, m_pb = 0;
  bit          m_sl = 0, m_sr = 0, m_cl = 0, m_cr = 0;
  bit          m_ovf = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [11:0] m_q[$];

  ps2_event_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .ev_shift   (ev_shift),
    .ev_ctrl    (ev_ctrl),
    .press_cnt  (press_cnt),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, do_push;
    logic [11:0] word;
    if (!rst_n) begin
      m_pe = 0; m_pb = 0; m_sl = 0; m_sr = 0; m_cl = 0; m_cr = 0;
      m_ovf = 0; m_cnt = '0; m_q.delete();
      return;
    end
    pop = (m_q.size() != 0) && ev_ready;
    do_push = 0;
    word = '0;
    if (byte_valid) begin
      if (byte_data == 8'hE0) begin
        m_pe = 1; m_pb = 0;
      end else if (byte_data == 8'hF0) begin
        m_pb = 1;
      end else begin
        if (!m_pe && byte_data == 8'h12) m_sl = !m_pb;
        if (!m_pe && byte_data == 8'h59) m_sr = !m_pb;
        if (byte_data == 8'h14) begin
          if (m_pe) m_cr = !m_pb; else m_cl = !m_pb;
        end
        word = {m_cl | m_cr, m_sl | m_sr, m_pb, m_pe, byte_data};
        if (m_q.size() == DEPTH && !pop) m_ovf = 1;
        else begin
          do_push = 1;
          if (!m_pb) m_cnt = m_cnt + 1'b1;
        end
        m_pe = 0; m_pb = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(word);
  endtask

  // Model advances on every active edge and on asynchronous reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Compare process: DUT outputs against the model on every falling edge
  initial forever begin
    logic [11:0] h;
    @(negedge clk);
    if (check_en) begin
      h = (m_q.size() != 0) ? m_q[0] : 12'h000;
      chk("ev_valid", ev_valid, m_q.size() != 0);
      chk("ev_head", {ev_ctrl, ev_shift, ev_break, ev_ext, ev_code}, h);
      chk("press_cnt", press_cnt, m_cnt);
      chk("fifo_level", fifo_level, m_q.size());
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic drive(input bit bv, input logic [7:0] b, input bit rdy);
    @(negedge clk);
    byte_valid = bv;
    byte_data  = b;
    ev_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    byte_valid = 0;
    ev_ready   = 0;
    #2 rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
  endtask

  task automatic expect_head(input string n, input logic [7:0] code, input bit ext,
                             input bit brk, input bit sh, input bit ct);
    chk(n, {ev_valid, ev_ctrl, ev_shift, ev_break, ev_ext, ev_code},
        {1'b1, ct, sh, brk, ext, code});
  endtask

  initial begin
    logic [7:0] b;
    int rdy_pct;
    do_reset();
    check_en = 1;
    @(posedge clk); #1;
    chk("reset_level", fifo_level, 0);
    chk("reset_valid", {ev_valid, ev_code, ev_ext, ev_break, ev_shift, ev_ctrl}, 0);
    chk("reset_cnt_ovf", {press_cnt, overflow}, 0);

    // make then break of 1C
    drive(1, 8'h1C, 0); drive(1, 8'hF0, 0); drive(1, 8'h1C, 0);
    chk("t1_level", fifo_level, 2);
    chk("t1_cnt", press_cnt, 1);
    expect_head("t1_ev0", 8'h1C, 0, 0, 0, 0);
    drive(0, 0, 1); expect_head("t1_ev1", 8'h1C, 0, 1, 0, 0);
    drive(0, 0, 1); chk("t1_empty", ev_valid, 0);

    // shift tracking
    do_reset();
    drive(1, 8'h12, 0); drive(1, 8'h1C, 0); drive(1, 8'hF0, 0);
    drive(1, 8'h12, 0); drive(1, 8'h1C, 0);
    chk("t2_cnt", press_cnt, 3);
    expect_head("t2_ev0", 8'h12, 0, 0, 1, 0);
    drive(0, 0, 1); expect_head("t2_ev1", 8'h1C, 0, 0, 1, 0);
    drive(0, 0, 1); expect_head("t2_ev2", 8'h12, 0, 1, 0, 0);
    drive(0, 0, 1); expect_head("t2_ev3", 8'h1C, 0, 0, 0, 0);

    // right ctrl via extended prefix
    do_reset();
    drive(1, 8'hE0, 0); drive(1, 8'h14, 0); drive(1, 8'h1C, 0);
    drive(1, 8'hE0, 0); drive(1, 8'hF0, 0); drive(1, 8'h14, 0);
    chk("t3_cnt", press_cnt, 2);
    expect_head("t3_ev0", 8'h14, 1, 0, 0, 1);
    drive(0, 0, 1); expect_head("t3_ev1", 8'h1C, 0, 0, 0, 1);
    drive(0, 0, 1); expect_head("t3_ev2", 8'h14, 1, 1, 0, 0);

    // overflow with 9 makes and a stalled consumer
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, 8'h15 + 8'(i), 0);
    drive(0, 0, 0);
    chk("t4_level", fifo_level, 8);
    chk("t4_ovf", overflow, 1);
    chk("t4_cnt", press_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      expect_head("t4_drain", 8'h15 + 8'(i), 0, 0, 0, 0);
      drive(0, 0, 1);
    end
    chk("t4_empty", ev_valid, 0);

    // full FIFO, simultaneous pop and push
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 8'h30 + 8'(i), 0);
    drive(1, 8'h3A, 1);
    drive(0, 0, 0);
    chk("t5_level", fifo_level, 8);
    chk("t5_ovf", overflow, 0);
    chk("t5_cnt", press_cnt, 9);
    for (int i = 0; i < 8; i++) begin
      expect_head("t5_drain", (i < 7) ? 8'h31 + 8'(i) : 8'h3A, 0, 0, 0, 0);
      drive(0, 0, 1);
    end

    // reset in the middle of an extended sequence
    do_reset();
    drive(1, 8'h1C, 0);
    drive(1, 8'hE0, 0);
    do_reset();
    drive(1, 8'h1C, 0);
    expect_head("t6_ev", 8'h1C, 0, 0, 0, 0);
    chk("t6_cnt", press_cnt, 1);
    chk("t6_level", fifo_level, 1);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      case ((c / 400) % 3)
        0:       rdy_pct = 10;
        1:       rdy_pct = 90;
        default: rdy_pct = 50;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'h12;
        3:       b = 8'h59;
        4:       b = 8'h14;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 699) == 0) do_reset();
      else drive($urandom_range(0, 99) < 60, b, $urandom_range(0, 99) < rdy_pct);
    end
    drive(0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
